// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO controller that drives an external dual-port RAM.
// The RAM has a registered read and a depth of 2**ADDR words.
// Port A of the RAM is the write port. Port B is the read port.
//
// Ports
//   clK, rst_N                  clock (rising edge), asynchronous active-low reset
//   wr_REQ, wr_DATA_IN          producer write request and data
//   rd_REQ                      consumer read request
//   rd_DATA_OUT, rd_VALID       read data, valid one cycle after an accepted read
//   ram_a_WR/ADDR/DATA          RAM port A (write side)
//   ram_b_WR/ADDR, ram_b_DATA   RAM port B (read side); ram_b_WR is tied low
//   full, empty                 occupancy is 2**ADDR / occupancy is 0
//   almost_FULL, almost_EMPTY   count >= AF_LVL / count <= AE_LVL
//   count                       occupancy, 0..2**ADDR
//   overflow, underflow         sticky request-while-full / request-while-empty
//   clr_ERR                     synchronous clear of the sticky error flags
module fifo_ctrl #(
   parameter int DATA   = 16,
   parameter int ADDR   = 5,
   parameter int AF_LVL = 2**ADDR - 2,
   parameter int AE_LVL = 2
) (
   input  logic            clK,
   input  logic            rst_N,
   input  logic            wr_REQ,
   input  logic [DATA-1:0] wr_DATA_IN,
   input  logic            rd_REQ,
   output logic [DATA-1:0] rd_DATA_OUT,
   output logic            rd_VALID,
   output logic            ram_a_WR,
   output logic [ADDR-1:0] ram_a_ADDR,
   output logic [DATA-1:0] ram_a_DATA,
   output logic            ram_b_WR,
   output logic [ADDR-1:0] ram_b_ADDR,
   input  logic [DATA-1:0] ram_b_DATA,
   output logic            full,
   output logic            empty,
   output logic            almost_FULL,
   output logic            almost_EMPTY,
   output logic [ADDR:0]   count,
   output logic            overflow,
   output logic            underflow,
   input  logic            clr_ERR
);

   localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(2**ADDR);
   localparam logic [ADDR:0] AF_C    = (ADDR+1)'(AF_LVL);
   localparam logic [ADDR:0] AE_C    = (ADDR+1)'(AE_LVL);
   localparam logic [ADDR:0] PTR_ONE = (ADDR+1)'(1);

   logic [ADDR:0] wr_ptr;
   logic [ADDR:0] rd_ptr;
   logic          wr_acc;
   logic          rd_acc;

   // Each pointer carries an extra wrap bit.
   // Their difference is therefore the exact occupancy.
   // This stays correct at 2**ADDR, where the address bits of the two pointers are equal.
   assign count        = wr_ptr - rd_ptr;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_FULL  = (count >= AF_C);
   assign almost_EMPTY = (count <= AE_C);

   // Accepts depend only on this cycle's flags.
   // A read in the same cycle does not free space for a write.
   // A write in the same cycle does not provide data for a read.
   assign wr_acc = wr_REQ & ~full;
   assign rd_acc = rd_REQ & ~empty;

   assign ram_a_WR    = wr_acc;
   assign ram_a_ADDR  = wr_ptr[ADDR-1:0];
   assign ram_a_DATA  = wr_DATA_IN;
   assign ram_b_WR    = 1'b0;
   assign ram_b_ADDR  = rd_ptr[ADDR-1:0];
   assign rd_DATA_OUT = ram_b_DATA;

   always_ff @(posedge clK or negedge rst_N) begin
      if (!rst_N) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rd_VALID  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         // The RAM registers its read on this same edge.
         // That is why valid is simply the accept, delayed by one cycle.
         rd_VALID <= rd_acc;
         // If an error is flagged in the same cycle as clr_ERR, the error wins.
         if (wr_REQ && full)  overflow  <= 1'b1;
         else if (clr_ERR)    overflow  <= 1'b0;
         if (rd_REQ && empty) underflow <= 1'b1;
         else if (clr_ERR)    underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

   localparam int DATA  = 16;
   localparam int ADDR  = 5;
   localparam int DEPTH = 2**ADDR;

   logic            clK = 1'b0;
   logic            rst_N;
   logic            wr_REQ;
   logic [DATA-1:0] wr_DATA_IN;
   logic            rd_REQ;
   logic [DATA-1:0] rd_DATA_OUT;
   logic            rd_VALID;
   logic            ram_a_WR;
   logic [ADDR-1:0] ram_a_ADDR;
   logic [DATA-1:0] ram_a_DATA;
   logic            ram_b_WR;
   logic [ADDR-1:0] ram_b_ADDR;
   logic [DATA-1:0] ram_b_DATA;
   logic            full, empty, almost_FULL, almost_EMPTY;
   logic [ADDR:0]   count;
   logic            overflow, underflow, clr_ERR;

   fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
      .clK(clK), .rst_N(rst_N),
      .wr_REQ(wr_REQ), .wr_DATA_IN(wr_DATA_IN),
      .rd_REQ(rd_REQ), .rd_DATA_OUT(rd_DATA_OUT), .rd_VALID(rd_VALID),
      .ram_a_WR(ram_a_WR), .ram_a_ADDR(ram_a_ADDR), .ram_a_DATA(ram_a_DATA),
      .ram_b_WR(ram_b_WR), .ram_b_ADDR(ram_b_ADDR), .ram_b_DATA(ram_b_DATA),
      .full(full), .empty(empty), .almost_FULL(almost_FULL), .almost_EMPTY(almost_EMPTY),
      .count(count), .overflow(overflow), .underflow(underflow), .clr_ERR(clr_ERR)
   );

   always #5 clK = ~clK;

   // Dual-port RAM with a registered read, instantiated alongside the controller.
   logic [DATA-1:0] mem [DEPTH];
   always @(posedge clK) begin
      if (ram_a_WR) mem[ram_a_ADDR] <= ram_a_DATA;
      ram_b_DATA <= mem[ram_b_ADDR];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference model
   logic [DATA-1:0] sb_q [$];
   int        m_cnt = 0;
   int        m_wp  = 0;
   int        m_rp  = 0;
   logic      m_ovf = 0, m_udf = 0, m_vld = 0;
   logic [DATA-1:0] dval = 16'h0100;

   task automatic model_reset();
      m_cnt = 0; m_wp = 0; m_rp = 0;
      m_ovf = 0; m_udf = 0; m_vld = 0;
      sb_q.delete();
   endtask

   task automatic chk_status();
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("almost_full", 32'(almost_FULL), 32'(m_cnt >= DEPTH - 2));
      chk("almost_empty", 32'(almost_EMPTY), 32'(m_cnt <= 2));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      chk("rd_valid", 32'(rd_VALID), 32'(m_vld));
   endtask

   // Called 1 time unit after a rising edge.
   // It drives one cycle of stimulus and checks the RAM-side outputs before the next edge.
   // After that edge it checks the result.
   task automatic step(input logic w, input logic [DATA-1:0] d, input logic r, input logic c);
      logic exp_wa, exp_ra;
      logic [DATA-1:0] exp_d;
      wr_REQ = w; wr_DATA_IN = d; rd_REQ = r; clr_ERR = c;
      exp_wa = w && (m_cnt != DEPTH);
      exp_ra = r && (m_cnt != 0);
      #2;
      chk("ram_a_wr", 32'(ram_a_WR), 32'(exp_wa));
      chk("ram_b_addr", 32'(ram_b_ADDR), 32'(m_rp % DEPTH));
      if (exp_wa) chk("ram_a_addr", 32'(ram_a_ADDR), 32'(m_wp % DEPTH));
      @(posedge clK);
      #1;
      if (exp_wa) begin
         sb_q.push_back(d);
         m_wp++;
      end
      if (exp_ra) m_rp++;
      if (w && m_cnt == DEPTH) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (r && m_cnt == 0) m_udf = 1;
      else if (c) m_udf = 0;
      m_cnt = m_cnt + int'(exp_wa) - int'(exp_ra);
      m_vld = exp_ra;
      chk_status();
      if (rd_VALID) begin
         if (sb_q.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
         else begin
            exp_d = sb_q.pop_front();
            chk("rd_data", 32'(rd_DATA_OUT), 32'(exp_d));
         end
      end
      wr_REQ = 0; rd_REQ = 0; clr_ERR = 0;
   endtask

   task automatic wr(input int n);
      for (int i = 0; i < n; i++) begin
         dval++;
         step(1'b1, dval, 1'b0, 1'b0);
      end
   endtask

   task automatic rd(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_N = 0; wr_REQ = 0; rd_REQ = 0; clr_ERR = 0; wr_DATA_IN = '0;
      repeat (2) @(posedge clK);
      #1;
      model_reset();
      chk_status();
      chk("ram_b_wr", 32'(ram_b_WR), 32'd0);
      rst_N = 1;

      // basic write three / read three
      step(1'b1, 16'h0001, 1'b0, 1'b0);
      step(1'b1, 16'h0002, 1'b0, 1'b0);
      step(1'b1, 16'h0003, 1'b0, 1'b0);
      rd(3);
      step(1'b0, '0, 1'b0, 1'b0);

      // fill to full, overflow, clear
      wr(DEPTH);
      dval++; step(1'b1, dval, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);

      // full with simultaneous read and write
      dval++; step(1'b1, dval, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);

      // drain to 10, then stream through wrap
      rd(21);
      for (int i = 0; i < 100; i++) begin
         dval++;
         step(1'b1, dval, 1'b1, 1'b0);
      end
      rd(10);

      // underflow; set wins over clear; clear
      rd(1);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);

      // empty with simultaneous read and write
      dval++; step(1'b1, dval, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);

      // build to 17 with rd_VALID high, then asynchronous reset
      wr(16);
      dval++; step(1'b1, dval, 1'b1, 1'b0);
      rst_N = 0;
      #1;
      model_reset();
      chk_status();
      #1;
      rst_N = 1;
      @(posedge clK);
      #1;
      chk_status();

      // operation after reset
      wr(2);
      rd(2);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
